// File: rtl/pipeline_elastic_register_if.sv
// rtl/pipeline_elastic_register_if.sv - handshake bundle for the elastic pipeline register
//
// Purpose: groups the upstream, downstream, flush and occupancy signals of
//          pipeline_elastic_register so the stage boundary is one port.
// Signals:
//   flush      - synchronous clear of all held entries (master -> slave)
//   in_valid   - upstream offers a beat (master -> slave)
//   in_ready   - buffer accepts a beat this cycle (slave -> master)
//   in_data    - upstream payload, WIDTH bits (master -> slave)
//   out_valid  - head entry presented downstream (slave -> master)
//   out_ready  - downstream takes the head entry (master -> slave)
//   out_data   - head payload, WIDTH bits (slave -> master)
//   count      - held entries 0..DEPTH (slave -> master)
interface pipeline_elastic_register_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipeline_elastic_register.sv
// rtl/pipeline_elastic_register.sv - DEPTH-entry valid/ready elastic buffer between pipeline stages
//
// Purpose: carries an opaque WIDTH-bit stage bundle through a small circular
//          FIFO with synchronous priority flush and occupancy report.
// Ports:
//   CLK - clock, rising edge
//   RST - asynchronous active-high reset (clears pointers and occupancy)
//   bus - pipeline_elastic_register_if.slave (flush, in_*/out_* handshakes, count)
module pipeline_elastic_register #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic                         CLK,
  input logic                         RST,
  pipeline_elastic_register_if.slave  bus
);
  // Pointer width kept at least 1 so DEPTH=1 still has a legal vector.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Handshake qualifiers depend only on registered state and flush, so
  // out_ready never reaches in_ready combinationally.
  assign bus.in_ready  = !w_full && !bus.flush;
  assign bus.out_valid = !w_empty && !bus.flush;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rp];
  assign bus.count     = r_cnt;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (bus.flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= next_ptr(r_wp);
      if (w_pop)  r_rp <= next_ptr(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; the write is masked during reset so beats offered
  // then never land in the array.
  always_ff @(posedge CLK) begin
    if (w_push && !RST) r_mem[r_wp] <= bus.in_data;
  end
endmodule

// File: tb/tb_pipeline_elastic_register.sv
// tb/tb_pipeline_elastic_register.sv - directed bench for pipeline_elastic_register at DEPTH 2, 3 and 1
module tb_pipeline_elastic_register;
  logic CLK;
  logic RST;
  int   total;
  int   bad;

  pipeline_elastic_register_if #(.WIDTH(32), .DEPTH(2)) if2 ();
  pipeline_elastic_register_if #(.WIDTH(32), .DEPTH(3)) if3 ();
  pipeline_elastic_register_if #(.WIDTH(32), .DEPTH(1)) if1 ();

  pipeline_elastic_register #(.WIDTH(32), .DEPTH(2)) u2 (.CLK(CLK), .RST(RST), .bus(if2.slave));
  pipeline_elastic_register #(.WIDTH(32), .DEPTH(3)) u3 (.CLK(CLK), .RST(RST), .bus(if3.slave));
  pipeline_elastic_register #(.WIDTH(32), .DEPTH(1)) u1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] pat;
  int          exp_cnt;
  int          sent;
  int          rcvd;
  int          cyc;
  logic        push;
  logic        pop;

  initial begin
    total = 0;
    bad   = 0;
    pat   = 32'b1010_0011_1100_0101_0010_1101_1000_0111;
    RST   = 1'b1;
    if2.flush = 0; if2.in_valid = 1; if2.in_data = 32'hDEAD; if2.out_ready = 0;
    if3.flush = 0; if3.in_valid = 0; if3.in_data = 0;        if3.out_ready = 0;
    if1.flush = 0; if1.in_valid = 0; if1.in_data = 0;        if1.out_ready = 0;

    // Reset: outputs idle, beats offered during reset are dropped.
    #1;
    chk("rst_vld", if2.out_valid, 0);
    chk("rst_rdy", if2.in_ready, 1);
    chk("rst_cnt", if2.count, 0);
    tick();
    tick();
    chk("rst_cnt_after_edges", if2.count, 0);
    chk("rst_data", if2.out_data, 0);
    RST = 1'b0;
    if2.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_vld", if2.out_valid, 0);
      chk("idle_data", if2.out_data, 0);
      chk("idle_cnt", if2.count, 0);
      chk("idle_rdy", if2.in_ready, 1);
    end

    // Streaming at DEPTH=2 with out_ready high: one beat per cycle, 1-cycle latency.
    if2.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      if2.in_valid = 1;
      if2.in_data  = 32'(i);
      #1;
      chk("stream_rdy", if2.in_ready, 1);
      if (i > 1) begin
        chk("stream_vld", if2.out_valid, 1);
        chk("stream_data", if2.out_data, 32'(i - 1));
        chk("stream_cnt", if2.count, 1);
      end
      tick();
    end
    if2.in_valid = 0;
    #1;
    chk("stream_last_data", if2.out_data, 8);
    chk("stream_last_cnt", if2.count, 1);
    tick();
    chk("stream_drain_cnt", if2.count, 0);
    chk("stream_drain_vld", if2.out_valid, 0);

    // Backpressure: fill, refuse 0xC, single pop, then 0xC accepted.
    if2.out_ready = 0;
    if2.in_valid = 1; if2.in_data = 32'hA;
    tick();
    chk("bp_cnt1", if2.count, 1);
    if2.in_data = 32'hB;
    tick();
    chk("bp_cnt2", if2.count, 2);
    if2.in_data = 32'hC;
    #1;
    chk("bp_full_rdy", if2.in_ready, 0);
    chk("bp_head_a", if2.out_data, 32'hA);
    tick();
    chk("bp_held_cnt", if2.count, 2);
    chk("bp_held_head", if2.out_data, 32'hA);
    if2.out_ready = 1;
    #1;
    chk("bp_no_comb_rdy", if2.in_ready, 0);
    tick();
    if2.out_ready = 0;
    #1;
    chk("bp_pop_cnt", if2.count, 1);
    chk("bp_head_b", if2.out_data, 32'hB);
    chk("bp_rdy_back", if2.in_ready, 1);
    tick();
    if2.in_valid = 0;
    chk("bp_c_cnt", if2.count, 2);
    chk("bp_head_b_still", if2.out_data, 32'hB);
    if2.out_ready = 1;
    tick();
    chk("bp_head_c", if2.out_data, 32'hC);
    tick();
    chk("bp_empty", if2.count, 0);

    // Flush priority over simultaneous push and pop.
    if2.out_ready = 0;
    if2.in_valid = 1; if2.in_data = 32'h11;
    tick();
    if2.in_data = 32'h22;
    tick();
    chk("fl_pre_cnt", if2.count, 2);
    if2.flush = 1; if2.in_data = 32'h33; if2.out_ready = 1;
    #1;
    chk("fl_rdy", if2.in_ready, 0);
    chk("fl_vld", if2.out_valid, 0);
    tick();
    if2.flush = 0; if2.in_valid = 0;
    #1;
    chk("fl_cnt", if2.count, 0);
    chk("fl_vld_after", if2.out_valid, 0);
    chk("fl_data_after", if2.out_data, 0);
    if2.in_valid = 1; if2.in_data = 32'h44; if2.out_ready = 0;
    tick();
    if2.in_valid = 0;
    chk("fl_new_head", if2.out_data, 32'h44);
    chk("fl_new_cnt", if2.count, 1);
    if2.out_ready = 1;
    tick();
    chk("fl_new_drain", if2.count, 0);

    // DEPTH=3 wrap under a fixed irregular out_ready pattern.
    q.delete();
    exp_cnt = 0; sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 80) begin
      if3.in_valid  = (sent < 10);
      if3.in_data   = 32'h100 + 32'(sent);
      if3.out_ready = pat[cyc % 32];
      #1;
      chk("d3_rdy", if3.in_ready, 32'(exp_cnt < 3));
      chk("d3_vld", if3.out_valid, 32'(exp_cnt > 0));
      chk("d3_cnt", if3.count, 32'(exp_cnt));
      if (exp_cnt > 0) chk("d3_data", if3.out_data, q[0]);
      chk("d3_inv", 32'(u3.r_wp), 32'((int'(u3.r_rp) + int'(u3.r_cnt)) % 3));
      push = if3.in_valid && (exp_cnt < 3);
      pop  = (exp_cnt > 0) && if3.out_ready;
      if (pop) begin
        void'(q.pop_front());
        rcvd++;
        exp_cnt--;
      end
      if (push) begin
        q.push_back(if3.in_data);
        sent++;
        exp_cnt++;
      end
      tick();
      cyc++;
    end
    if3.in_valid = 0; if3.out_ready = 0;
    chk("d3_all_received", 32'(rcvd), 10);
    chk("d3_end_cnt", if3.count, 0);

    // DEPTH=1: accepts every other cycle with out_ready high.
    if1.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if1.in_valid = 1;
      if1.in_data  = 32'h50 + 32'(i / 2);
      #1;
      chk("d1_rdy", if1.in_ready, 32'(i % 2 == 0));
      chk("d1_vld", if1.out_valid, 32'(i % 2 == 1));
      if (i % 2 == 1) chk("d1_data", if1.out_data, 32'h50 + 32'(i / 2));
      tick();
    end

    // Asynchronous reset mid-cycle while holding a beat.
    if1.out_ready = 0; if1.in_data = 32'h77;
    tick();
    if1.in_valid = 0;
    chk("ar_held_vld", if1.out_valid, 1);
    chk("ar_held_cnt", if1.count, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_vld_async", if1.out_valid, 0);
    chk("ar_cnt_async", if1.count, 0);
    chk("ar_data_async", if1.out_data, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("ar_post_cnt", if1.count, 0);
    chk("ar_post_rdy", if1.in_ready, 1);
    chk("ar_post_vld", if1.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_elastic_register.md
Name: pipeline_elastic_register

Overview:
- Parametrised successor to the fixed-field pipeline latch used between CPU stages.
- Carries an opaque WIDTH-bit payload (the packed stage bundle) through a DEPTH-entry elastic buffer.
- Uses a valid/ready handshake instead of a global enable, so a downstream stall no longer needs a combinational enable network.
- Flush is synchronous and priority-ordered rather than an asynchronous clear.
- Reports occupancy for the hazard unit.

Parameters:
- WIDTH, 32: payload width in bits; must be >= 1.
- DEPTH, 2: number of buffer entries; must be >= 1. DEPTH >= 2 gives full throughput. Non-power-of-2 values are legal.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all held entries.
- in_valid  input  1  upstream offers a beat.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry presented downstream.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  WIDTH  head payload.
- count  output  $clog2(DEPTH+1)  number of held entries, 0..DEPTH.

Behaviour:
- State:
  - storage array mem[0..DEPTH-1].
  - write pointer wp and read pointer rp, each 0..DEPTH-1.
  - occupancy register cnt, driven directly on count.
- Reset: while RST is high, cnt=0, wp=0, rp=0 asynchronously. Outputs during reset: out_valid=0, out_data=0, count=0, in_ready=1. Beats presented while RST is high are not stored. mem is not reset.
- Derived signals:
  - full = (cnt==DEPTH); empty = (cnt==0).
  - in_ready = !full && !flush. Registered-state only: no combinational path from out_ready to in_ready.
  - out_valid = !empty && !flush.
  - out_data = mem[rp] when !empty, else all zeros.
- Handshakes:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_data is sampled only on push; it is don't-care otherwise.
  - out_valid, once asserted, stays asserted with out_data stable until pop or flush.
- Clock-edge update when RST is low, in priority order:
  1. flush=1: cnt, wp and rp all go to 0. Any in_valid that cycle is refused (in_ready=0). No pop occurs that cycle (out_valid=0). flush overrides push/pop unconditionally.
  2. push only: mem[wp]<=in_data; wp advances; cnt+1.
  3. pop only: rp advances; cnt-1.
  4. push and pop together: write, both pointers advance, cnt unchanged. Legal at any 0<cnt<DEPTH.
  5. Neither: hold.
- Pointer advance: wraps DEPTH-1 -> 0. For DEPTH=1, both pointers stay 0.
- Latency: a beat pushed at edge N is visible on out_valid/out_data after edge N (1-cycle minimum). Ordering is strict FIFO.
- Throughput:
  - DEPTH=1: at most one beat every 2 cycles, because in_ready is low while full.
  - DEPTH>=2 with out_ready held high: one beat per cycle sustained.
- Boundaries:
  - Full with out_ready=1: pop happens, push is refused that cycle; in_ready rises the next cycle.
  - Empty: out_ready is ignored; cnt never underflows.
  - Reset asserted mid-stream: all held beats are lost, with no partial state.
- Assertions for the bench:
  - cnt <= DEPTH.
  - wp == (rp + cnt) mod DEPTH.
  - no push while in_ready=0.
  - out_data stable while out_valid && !out_ready.

Test Plan:
- Reset/idle: RST pulse, then idle 3 cycles -> out_valid=0, out_data=0, count=0, in_ready=1 throughout.
- Streaming: DEPTH=2, WIDTH=32, out_ready=1, push 0x1,0x2,...,0x8 on consecutive cycles -> each beat appears exactly 1 cycle after its push, in order; in_ready never drops; count stays 1 after the first beat.
- Backpressure/full: DEPTH=2, out_ready=0, in_valid=1 with 0xA,0xB,0xC -> count reaches 2, in_ready=0, 0xC held upstream. Then out_ready=1 for one cycle -> 0xA pops, 0xC accepted the following cycle; output order is 0xA,0xB,0xC.
- Flush priority: count=2 holding 0x11,0x22; flush=1 with in_valid=1 (0x33) and out_ready=1 -> in_ready=0 and out_valid=0 during flush; after the edge count=0, and 0x33, 0x11, 0x22 never emerge.
- Wrap, non-power-of-2: DEPTH=3, 10 beats under random out_ready -> pointers wrap 2->0, all beats emerge in order, and the invariant wp==(rp+cnt) mod 3 holds every cycle.
- DEPTH=1 and async reset: DEPTH=1 streaming with out_ready=1 -> accepts every other cycle. Then RST asserted mid-cycle with count=1 -> out_valid falls immediately without waiting for CLK; after release, count=0.
